ref_force_wb_serializer: RTL and testbench

- Sits directly downstream of the NUM_ACC per-cell reference-particle force accumulators in the RL LJ evaluation unit.
- Captures their one-cycle accumulated-force pulses, which may coincide across lanes, into per-lane FIFOs.
- Serializes them, round-robin, onto a single valid/ready writeback stream towards the force cache.
- Signals completion of each writeback round, where a round is delimited by the accumulators' start_wb pulses.

---
 rtl/ref_force_wb_serializer_if.sv | 37 +++
 rtl/ref_force_wb_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_ref_force_wb_serializer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_force_wb_serializer_if.sv
// Writeback stream from the reference-force serializer to the force cache.
// The serializer drives valid and payload; the cache drives ready.
interface ref_force_wb_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 29,
  parameter int unsigned LANE_W     = 3
);

  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [LANE_W-1:0]     out_lane;
  logic [DATA_WIDTH-1:0] out_force_x;
  logic [DATA_WIDTH-1:0] out_force_y;
  logic [DATA_WIDTH-1:0] out_force_z;

  modport master (
    output out_valid,
    output out_id,
    output out_lane,
    output out_force_x,
    output out_force_y,
    output out_force_z,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_lane,
    input  out_force_x,
    input  out_force_y,
    input  out_force_z,
    output out_ready
  );

endinterface

// File: rtl/ref_force_wb_serializer.sv
// Reference-force writeback serializer.
// Captures per-lane accumulated-force pulses into small per-lane FIFOs and drains them
// round-robin through a single-entry output register onto one valid/ready stream.
// A writeback round opened by any start_wb pulse is closed with a one-cycle wb_done
// once every captured entry has been handed off.
module ref_force_wb_serializer #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned PARTICLE_ID_WIDTH = 20,
  parameter int unsigned CELL_ID_WIDTH     = 3,
  parameter int unsigned ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int unsigned NUM_ACC           = 7,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned LANE_W            = $clog2(NUM_ACC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ACC-1:0]            in_valid,
  input  logic [NUM_ACC*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_x,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_y,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_z,
  input  logic [NUM_ACC-1:0]            in_start_wb,
  ref_force_wb_serializer_if.master     wb,
  output logic                          wb_done,
  output logic [NUM_ACC-1:0]            overflow,
  output logic                          busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] z;
  } entry_t;

  // Per-lane FIFO state
  entry_t             mem_q    [NUM_ACC][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_ACC];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_ACC];
  logic [CNT_W-1:0]   count_q  [NUM_ACC];
  logic [CNT_W-1:0]   count_d  [NUM_ACC];
  entry_t             lane_in  [NUM_ACC];

  logic [NUM_ACC-1:0] nonempty;
  logic [NUM_ACC-1:0] pop;
  logic [NUM_ACC-1:0] push_ok;

  // Arbitration
  logic [LANE_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic               load_en;
  logic               grant_found;
  logic [LANE_W-1:0]  grant_lane;

  // Output register and round tracking
  logic               out_valid_q, out_valid_d;
  entry_t             out_entry_q, out_entry_d;
  logic [LANE_W-1:0]  out_lane_q, out_lane_d;
  logic               round_pending_q, round_pending_d;
  logic               done_cond;
  logic               wb_done_q;
  logic [NUM_ACC-1:0] overflow_q;
  logic               busy_q, busy_d;

  // Unpack the flat per-lane input buses and derive FIFO occupancy flags.
  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      lane_in[i].id = in_id[i*ID_WIDTH +: ID_WIDTH];
      lane_in[i].x  = in_force_x[i*DATA_WIDTH +: DATA_WIDTH];
      lane_in[i].y  = in_force_y[i*DATA_WIDTH +: DATA_WIDTH];
      lane_in[i].z  = in_force_z[i*DATA_WIDTH +: DATA_WIDTH];
      nonempty[i]   = (count_q[i] != '0);
    end
  end

  // Round-robin grant: first non-empty lane at or after rr_ptr, wrapping at NUM_ACC.
  always_comb begin
    int idx;
    idx         = 0;
    load_en     = ~out_valid_q | wb.out_ready;
    grant_found = 1'b0;
    grant_lane  = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_ACC;
      if (!grant_found && nonempty[idx]) begin
        grant_found = 1'b1;
        grant_lane  = LANE_W'(idx);
      end
    end
  end

  // FIFO push/pop control; a full lane still accepts a push when it is popped this cycle.
  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      pop[i]     = load_en & grant_found & (grant_lane == LANE_W'(i));
      push_ok[i] = in_valid[i] & ((count_q[i] != CNT_W'(FIFO_DEPTH)) | pop[i]);
      count_d[i] = count_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
    end
  end

  // Output register load, round-robin advance, round completion and busy next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = 1'b0;

    if (load_en) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_entry_d = mem_q[grant_lane][rd_ptr_q[grant_lane]];
        out_lane_d  = grant_lane;
        rr_ptr_d    = (grant_lane == LANE_W'(NUM_ACC - 1)) ? '0 : grant_lane + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Round closes only when nothing is queued, nothing arrives and the output hands off
    // without reloading; a start_wb on the same edge re-arms the next round.
    done_cond = round_pending_q & ~(|nonempty) & ~(|push_ok) &
                (~out_valid_q | (wb.out_ready & ~grant_found));
    round_pending_d = (|in_start_wb) | (round_pending_q & ~done_cond);

    for (int i = 0; i < NUM_ACC; i++) begin
      if (count_d[i] != '0) begin
        busy_d = 1'b1;
      end
    end
    if (out_valid_d) begin
      busy_d = 1'b1;
    end
  end

  // FIFO storage: needs no reset since pointers and counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACC; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wr_ptr_q[i]] <= lane_in[i];
      end
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (push_ok[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        count_q[i] <= count_d[i];
      end
    end
  end

  // Output register, arbitration pointer and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_entry_q     <= '0;
      out_lane_q      <= '0;
      rr_ptr_q        <= '0;
      round_pending_q <= 1'b0;
      wb_done_q       <= 1'b0;
      overflow_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_entry_q     <= out_entry_d;
      out_lane_q      <= out_lane_d;
      rr_ptr_q        <= rr_ptr_d;
      round_pending_q <= round_pending_d;
      wb_done_q       <= done_cond;
      overflow_q      <= overflow_q | (in_valid & ~push_ok);
      busy_q          <= busy_d;
    end
  end

  assign wb.out_valid   = out_valid_q;
  assign wb.out_id      = out_entry_q.id;
  assign wb.out_lane    = out_lane_q;
  assign wb.out_force_x = out_entry_q.x;
  assign wb.out_force_y = out_entry_q.y;
  assign wb.out_force_z = out_entry_q.z;
  assign wb_done        = wb_done_q;
  assign overflow       = overflow_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ref_force_wb_serializer.sv
// Bench for ref_force_wb_serializer: constant-expectation vector table, directed corner
// sequences and random traffic, all checked every cycle against a queue-based model.
module tb_ref_force_wb_serializer;

  localparam int DW = 32;
  localparam int IW = 29;
  localparam int N  = 7;
  localparam int D  = 4;
  localparam int LW = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
  } ent_t;

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  s;
    logic          r;
    logic          ev;
    logic [LW-1:0] el;
    logic          ed;
    logic          eb;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*IW-1:0] in_id;
  logic [N*DW-1:0] in_force_x;
  logic [N*DW-1:0] in_force_y;
  logic [N*DW-1:0] in_force_z;
  logic [N-1:0]    in_start_wb;
  logic            wb_done;
  logic [N-1:0]    overflow;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t         mq [N][$];
  logic [N-1:0] m_ov;
  int           m_rr;
  bit           m_pend;
  bit           m_valid;
  bit           m_done;
  bit           m_busy;
  ent_t         m_out;
  int           m_lane;

  vec_t tbl [10];

  always #5 clk = ~clk;

  ref_force_wb_serializer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .LANE_W(LW)) wb ();

  ref_force_wb_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_id       (in_id),
    .in_force_x  (in_force_x),
    .in_force_y  (in_force_y),
    .in_force_z  (in_force_z),
    .in_start_wb (in_start_wb),
    .wb          (wb.master),
    .wb_done     (wb_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t lane_in(input int i);
    ent_t e;
    e.id = in_id[i*IW +: IW];
    e.x  = in_force_x[i*DW +: DW];
    e.y  = in_force_y[i*DW +: DW];
    e.z  = in_force_z[i*DW +: DW];
    return e;
  endfunction

  task automatic set_lane(input int i, input logic [IW-1:0] id, input logic [DW-1:0] x,
                          input logic [DW-1:0] y, input logic [DW-1:0] z);
    in_id[i*IW +: IW]      = id;
    in_force_x[i*DW +: DW] = x;
    in_force_y[i*DW +: DW] = y;
    in_force_z[i*DW +: DW] = z;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ov = '0; m_rr = 0; m_pend = 0; m_valid = 0; m_done = 0; m_busy = 0;
    m_out = '0; m_lane = 0;
  endtask

  task automatic check_model();
    chk("out_valid", 128'(wb.out_valid), 128'(m_valid));
    if (m_valid) begin
      chk("out_lane", 128'(wb.out_lane), 128'(m_lane));
      chk("out_id", 128'(wb.out_id), 128'(m_out.id));
      chk("out_force_x", 128'(wb.out_force_x), 128'(m_out.x));
      chk("out_force_y", 128'(wb.out_force_y), 128'(m_out.y));
      chk("out_force_z", 128'(wb.out_force_z), 128'(m_out.z));
    end
    chk("wb_done", 128'(wb_done), 128'(m_done));
    chk("overflow", 128'(overflow), 128'(m_ov));
    chk("busy", 128'(busy), 128'(m_busy));
  endtask

  // One clock: model the edge from the current inputs, then compare after the edge.
  task automatic step();
    bit           load;
    int           g;
    bit           empty;
    logic [N-1:0] acc;
    load  = !m_valid || wb.out_ready;
    g     = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int l;
        l = (m_rr + k) % N;
        if (g < 0 && mq[l].size() > 0) g = l;
      end
    end
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        if (mq[i].size() < D || g == i) acc[i] = 1'b1;
        else m_ov[i] = 1'b1;
      end
    end
    empty = 1;
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) empty = 0;
    m_done = m_pend && empty && (acc == '0) && (!m_valid || (wb.out_ready && g < 0));
    if (g >= 0) begin
      m_out   = mq[g].pop_front();
      m_valid = 1;
      m_lane  = g;
      m_rr    = (g + 1) % N;
    end else if (load) begin
      m_valid = 0;
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(lane_in(i));
    if (in_start_wb != '0) m_pend = 1;
    else if (m_done) m_pend = 0;
    m_busy = m_valid;
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) m_busy = 1;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    in_valid = '0; in_start_wb = '0; wb.out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid = '0; in_start_wb = '0; wb.out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nbeats;

    tbl[0] = '{v: 7'h7F, s: 7'h7F, r: 1'b1, ev: 1'b0, el: 3'd0, ed: 1'b0, eb: 1'b1};
    for (int k = 1; k <= 7; k++)
      tbl[k] = '{v: '0, s: '0, r: 1'b1, ev: 1'b1, el: LW'(k - 1), ed: 1'b0, eb: 1'b1};
    tbl[8] = '{v: '0, s: '0, r: 1'b1, ev: 1'b0, el: 3'd0, ed: 1'b1, eb: 1'b0};
    tbl[9] = '{v: '0, s: '0, r: 1'b1, ev: 1'b0, el: 3'd0, ed: 1'b0, eb: 1'b0};

    in_id = '0; in_force_x = '0; in_force_y = '0; in_force_z = '0;
    do_reset();
    check_model();
    chk("reset_out_valid", 128'(wb.out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));

    // Single lane pass-through, then a round closed by start_wb
    set_lane(3, 29'h0A00005, 32'h3F800000, 32'h40000000, 32'hBF800000);
    in_valid = 7'b0001000;
    step();
    chk("single_t1_valid", 128'(wb.out_valid), 128'(0));
    in_valid = '0;
    step();
    chk("single_lane", 128'(wb.out_lane), 128'(3));
    chk("single_id", 128'(wb.out_id), 128'(29'h0A00005));
    chk("single_x", 128'(wb.out_force_x), 128'(32'h3F800000));
    chk("single_z", 128'(wb.out_force_z), 128'(32'hBF800000));
    in_start_wb = 7'b0001000;
    step();
    in_start_wb = '0;
    step();
    chk("single_wb_done", 128'(wb_done), 128'(1));
    step();
    chk("single_wb_done_clr", 128'(wb_done), 128'(0));

    // All seven lanes at once with start_wb: constant-expectation vector table
    do_reset();
    for (int i = 0; i < N; i++)
      set_lane(i, IW'(32'h100 + i), 32'h3F800000 + i, 32'h1000 + i, 32'h2000 + i);
    for (int r = 0; r < 10; r++) begin
      in_valid = tbl[r].v; in_start_wb = tbl[r].s; wb.out_ready = tbl[r].r;
      step();
      chk("tbl_valid", 128'(wb.out_valid), 128'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk("tbl_lane", 128'(wb.out_lane), 128'(tbl[r].el));
        chk("tbl_id", 128'(wb.out_id), 128'(32'h100 + tbl[r].el));
      end
      chk("tbl_wb_done", 128'(wb_done), 128'(tbl[r].ed));
      chk("tbl_busy", 128'(busy), 128'(tbl[r].eb));
    end

    // Backpressure: three entries, output held for five cycles
    set_lane(1, 29'h111, 32'hA1, 32'hB1, 32'hC1);
    set_lane(4, 29'h444, 32'hA4, 32'hB4, 32'hC4);
    set_lane(5, 29'h555, 32'hA5, 32'hB5, 32'hC5);
    in_valid = 7'b0110010; wb.out_ready = 1'b0;
    step();
    in_valid = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_lane", 128'(wb.out_lane), 128'(1));
      chk("hold_id", 128'(wb.out_id), 128'(29'h111));
    end
    wb.out_ready = 1'b1;
    step();
    chk("bp_lane4", 128'(wb.out_lane), 128'(4));
    step();
    chk("bp_lane5", 128'(wb.out_lane), 128'(5));
    idle(3);

    // Lane 0 full while output stalled; push on the popping cycle is accepted
    wb.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, IW'(32'h800 + c), 32'h10 + c, 32'h20 + c, 32'h30 + c);
      in_valid = 7'b0000001;
      step();
    end
    set_lane(0, 29'h8FF, 32'hFF, 32'hFE, 32'hFD);
    wb.out_ready = 1'b1;
    step();
    chk("full_pop_ovf", 128'(overflow), 128'(0));
    idle(8);

    // Lane 2 overflow: six pushes with output stalled, one is dropped
    wb.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_lane(2, IW'(32'h200 + c), 32'h40 + c, 32'h50 + c, 32'h60 + c);
      in_valid = 7'b0000100;
      step();
    end
    chk("ovf_set", 128'(overflow[2]), 128'(1));
    chk("ovf_held_id", 128'(wb.out_id), 128'(29'h200));
    in_valid = '0; wb.out_ready = 1'b1;
    nbeats = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (wb.out_valid) nbeats++;
    end
    chk("ovf_beats", 128'(nbeats), 128'(5));
    chk("ovf_sticky", 128'(overflow[2]), 128'(1));

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 9) < 3);
        set_lane(i, IW'($urandom), $urandom, $urandom, $urandom);
      end
      in_start_wb = '0;
      if ($urandom_range(0, 24) == 0) in_start_wb[$urandom_range(0, N - 1)] = 1'b1;
      wb.out_ready = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 8 : 3));
      step();
    end
    idle(40);

    // Asynchronous reset mid-drain with a round pending
    wb.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) set_lane(i, IW'(32'h300 + i), 32'h1, 32'h2, 32'h3);
    in_valid = 7'b0011111; in_start_wb = 7'b0000001;
    step();
    in_valid = '0; in_start_wb = '0;
    step();
    chk("pre_rst_valid", 128'(wb.out_valid), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(wb.out_valid), 128'(0));
    chk("rst_out_id", 128'(wb.out_id), 128'(0));
    chk("rst_out_lane", 128'(wb.out_lane), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_wb_done", 128'(wb_done), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb.out_ready = 1'b1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
